seq_detect_mask: RTL and testbench

Parametrised serial bit-sequence detector with a runtime-programmable pattern and a per-bit care mask. It supports overlapping and non-overlapping match modes, a valid qualifier on the input stream, a synchronous clear, and a saturating match counter. It sits on a serial data path (frame-sync / preamble detection) and pulses `match` once per detected occurrence.

---
 rtl/seq_detect_mask.sv | 84 ++++++++
 tb/tb_seq_detect_mask.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_mask.sv
// Serial bit-sequence detector with a programmable pattern, a per-bit care mask,
// overlapping/non-overlapping match modes and a saturating match counter.
module seq_detect_mask #(
    parameter int unsigned LEN   = 9,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             a_valid,
    input  logic             a,
    input  logic [LEN-1:0]   pattern,
    input  logic [LEN-1:0]   mask,
    input  logic             overlap_en,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             fill_done
);

    localparam int unsigned FILL_W = $clog2(LEN + 1);
    localparam logic [FILL_W-1:0] FillFull = FILL_W'(LEN);

    logic [LEN-1:0]    hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              match_q, match_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [LEN-1:0]    cand;
    logic              fill_ready;
    logic              hit;

    // The incoming bit completes a full window once LEN-1 bits are already held,
    // so the all-zero reset history can never be compared.
    assign cand       = {hist_q[LEN-2:0], a};
    assign fill_ready = (fill_q >= (FillFull - 1'b1));
    assign hit        = a_valid && fill_ready && (((cand ^ pattern) & mask) == '0);

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (a_valid) begin
            hist_d  = cand;
            match_d = hit;
            if (hit) begin
                // Non-overlap mode restarts the window so the next match needs LEN fresh bits.
                fill_d = overlap_en ? FillFull : '0;
            end else if (fill_q != FillFull) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (match_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign fill_done = (fill_q == FillFull);

endmodule

// File: tb/tb_seq_detect_mask.sv
// Scoreboard bench for seq_detect_mask: directed bit streams with hand-computed
// per-cycle expectations, checked by an independent monitor process.
module tb_seq_detect_mask;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       a_valid;
    logic       a;
    logic [8:0] pattern;
    logic [8:0] mask;
    logic       overlap_en;
    logic       match;
    logic [7:0] match_cnt;
    logic       fill_done;
    logic       match_s;
    logic [1:0] match_cnt_s;
    logic       fill_done_s;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    typedef struct packed {
        logic       m;
        logic [7:0] cnt;
        logic       fd;
        logic [1:0] cs;
    } exp_t;

    exp_t sb_q[$];

    seq_detect_mask #(.LEN(9), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .a_valid   (a_valid),
        .a         (a),
        .pattern   (pattern),
        .mask      (mask),
        .overlap_en(overlap_en),
        .match     (match),
        .match_cnt (match_cnt),
        .fill_done (fill_done)
    );

    seq_detect_mask #(.LEN(9), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .a_valid   (a_valid),
        .a         (a),
        .pattern   (pattern),
        .mask      (mask),
        .overlap_en(overlap_en),
        .match     (match_s),
        .match_cnt (match_cnt_s),
        .fill_done (fill_done_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every cycle with a pending expectation is checked after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (match !== e.m || match_cnt !== e.cnt || fill_done !== e.fd
                    || match_cnt_s !== e.cs) begin
                    errors++;
                    $display("FAIL sb_check_%0d: got match=%0b cnt=%0d fd=%0b cnt_sat=%0d, want match=%0b cnt=%0d fd=%0b cnt_sat=%0d",
                             checks, match, match_cnt, fill_done, match_cnt_s,
                             e.m, e.cnt, e.fd, e.cs);
                end
            end
        end
    end

    task automatic step(input logic v, input logic b, input logic c, input logic em,
                        input logic efd);
        exp_t e;
        a_valid = v;
        a       = b;
        clr     = c;
        if (c) exp_cnt = 0;
        else if (em) exp_cnt++;
        e.m   = em;
        e.cnt = 8'(exp_cnt);
        e.fd  = efd;
        e.cs  = (exp_cnt > 3) ? 2'd3 : 2'(exp_cnt);
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        clr     = 1'b0;
    endtask

    task automatic run(input string bits, input string em, input string efd);
        for (int i = 0; i < bits.len(); i++) begin
            step(1'b1, bits[i] == "1", 1'b0, em[i] == "1", efd[i] == "1");
        end
    endtask

    task automatic idle(input int n, input logic efd);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, efd);
    endtask

    task automatic direct_check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        clr        = 1'b0;
        a_valid    = 1'b0;
        a          = 1'b0;
        pattern    = 9'b011000110;
        mask       = 9'b111000111;
        overlap_en = 1'b0;
        repeat (2) @(negedge clk);
        direct_check("reset_match", {7'd0, match}, 8'd0);
        direct_check("reset_cnt", match_cnt, 8'd0);
        direct_check("reset_fill_done", {7'd0, fill_done}, 8'd0);
        rst_n = 1'b1;

        // Five bits in (fill=5), then an asynchronous reset between edges.
        run("10110", "00000", "00000");
        #2 rst_n = 1'b0;
        #1;
        direct_check("async_rst_match", {7'd0, match}, 8'd0);
        direct_check("async_rst_cnt", match_cnt, 8'd0);
        direct_check("async_rst_fill_done", {7'd0, fill_done}, 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4, 1'b0);

        // Masked pattern, non-overlap: two matches with different don't-care bits.
        run("011101110", "000000001", "000000000");
        run("011010110", "000000001", "000000000");
        // Gap of three invalid cycles between bits 4 and 5.
        run("0111", "0000", "0000");
        idle(3, 1'b0);
        run("01110", "00001", "00000");
        // Only eight bits: no match, fill not complete.
        run("01110111", "00000000", "00000000");
        idle(3, 1'b0);

        // Overlapping matches on an alternating stream.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        pattern    = 9'b101010101;
        mask       = 9'h1FF;
        overlap_en = 1'b1;
        run("1010101010101", "0000000010101", "0000000011111");

        // Same stream, non-overlapping.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        overlap_en = 1'b0;
        run("1010101010101", "0000000010000", "0000000000000");

        // All-zero mask: every valid bit after fill is a hit; 2-bit counter saturates at 3.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        mask       = 9'h000;
        overlap_en = 1'b1;
        run("10101010101010101010", "00000000111111111111", "00000000111111111111");

        // clr together with the completing bit discards it; nine fresh bits needed after.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        mask = 9'h1FF;
        run("10101010", "00000000", "00000000");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        run("10101010", "00000000", "00000000");
        run("1", "1", "1");
        idle(2, 1'b1);

        @(negedge clk);
        direct_check("scoreboard_drained", 8'(sb_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
